// File: rtl/block_loader_if.sv
// ---------------------------------------------------------------------------
// block_loader_if
// Bundles the pixel-in and block-out handshakes of block_loader.
//   pix_in    : pixel, raster order within an 8x8 block
//   pix_valid : pix_in is valid this cycle
//   pix_ready : loader accepts a pixel this cycle
//   blk_data  : assembled block, element (r,c) at [(r*8+c)*N +: N]
//   blk_valid : blk_data holds a complete block
//   blk_ready : consumer takes the block this cycle
//   blk_count : blocks handed off since reset (wraps at 2^16)
// slave  = the loader side, master = the producer/consumer side.
// ---------------------------------------------------------------------------
interface block_loader_if #(
    parameter int N    = 16,
    parameter int IN_W = 8
);
    logic [IN_W-1:0]   pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [N*64-1:0]   blk_data;
    logic              blk_valid;
    logic              blk_ready;
    logic [15:0]       blk_count;

    modport slave (
        input  pix_in, pix_valid, blk_ready,
        output pix_ready, blk_data, blk_valid, blk_count
    );

    modport master (
        output pix_in, pix_valid, blk_ready,
        input  pix_ready, blk_data, blk_valid, blk_count
    );
endinterface

// File: rtl/block_loader.sv
// ---------------------------------------------------------------------------
// block_loader
// Collects raster-order pixels into 8x8 blocks using two ping/pong buffers,
// optionally level-shifting each pixel to signed, and presents a complete
// block as one flat N*64-bit word for the 2-D DCT.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (clears all state and buffers)
//   bus : block_loader_if.slave (pixel stream in, block handshake out)
// ---------------------------------------------------------------------------
module block_loader #(
    parameter int N           = 16,
    parameter int IN_W        = 8,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic          clk,
    input  logic          rst,
    block_loader_if.slave bus
);

    // Offset removed from every pixel: 2^(IN_W-1) when level shifting.
    localparam logic [N-1:0] SHIFT_OFS =
        (LEVEL_SHIFT != 0) ? (N'(1) << (IN_W - 1)) : '0;

    logic [1:0]   full_q, full_d;
    logic         wr_sel_q, wr_sel_d;
    logic         rd_sel_q, rd_sel_d;
    logic [5:0]   wr_idx_q, wr_idx_d;
    logic [15:0]  blk_count_q, blk_count_d;

    logic [N-1:0] mem_q [2][64];

    logic         accept;
    logic         handoff;
    logic [N-1:0] pix_ext;
    logic [N*64-1:0] blk_data_w;

    assign accept  = bus.pix_valid && !full_q[wr_sel_q];
    assign handoff = full_q[rd_sel_q] && bus.blk_ready;

    // Zero-extend then subtract in N bits: since N > IN_W the result is the
    // correct two's-complement value of (p - offset).
    assign pix_ext = {{(N-IN_W){1'b0}}, bus.pix_in} - SHIFT_OFS;

    // Completion touches full[wr_sel] (which must be empty to accept) and
    // handoff touches full[rd_sel] (which must be full), so when both happen
    // in one cycle they always act on different buffers.
    always_comb begin
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_idx_d    = wr_idx_q;
        blk_count_d = blk_count_q;
        if (accept) begin
            wr_idx_d = wr_idx_q + 6'd1;
            if (wr_idx_q == 6'd63) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end
        end
        if (handoff) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            blk_count_d      = blk_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_idx_q    <= '0;
            blk_count_q <= '0;
        end else begin
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_idx_q    <= wr_idx_d;
            blk_count_q <= blk_count_d;
        end
    end

    // One register per buffer element; buffers must clear on reset so the
    // storage is plain flops rather than block RAM.
    for (genvar gi = 0; gi < 128; gi++) begin : g_mem
        localparam int BUF = gi / 64;
        localparam int IDX = gi % 64;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[BUF][IDX] <= '0;
            end else if (accept && (wr_sel_q == BUF[0]) && (wr_idx_q == IDX[5:0])) begin
                mem_q[BUF][IDX] <= pix_ext;
            end
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_out
        assign blk_data_w[gi*N +: N] = mem_q[rd_sel_q][gi];
    end

    assign bus.pix_ready = !full_q[wr_sel_q];
    assign bus.blk_valid = full_q[rd_sel_q];
    assign bus.blk_data  = blk_data_w;
    assign bus.blk_count = blk_count_q;

endmodule
